// File: rtl/ctx_pkg.sv
// Shared types and constants for the register-context save/restore engine.
// The optional CTX_CHECKSUM_EN build relies on DATA_W for its accumulator width.
package ctx_pkg;

    localparam int unsigned NREG   = 16;
    localparam int unsigned REG_W  = $clog2(NREG);
    localparam int unsigned DATA_W = 32;

    localparam logic OP_SAVE    = 1'b0;
    localparam logic OP_RESTORE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAVE_LD = 3'd1,
        ST_SAVE_TX = 3'd2,
        ST_RESTORE = 3'd3,
        ST_DONE    = 3'd4
    } ctx_state_e;

    // Register index successor; the register file wraps at NREG.
    function automatic logic [REG_W-1:0] next_idx(input logic [REG_W-1:0] idx);
        return REG_W'(idx + 1'b1);
    endfunction

endpackage

// File: rtl/ctx_chk.sv
// Modulo-2^32 checksum of transferred context words; only built with CTX_CHECKSUM_EN.
module ctx_chk
    import ctx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [DATA_W-1:0] sum_o
);

    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = DATA_W'(sum_q + word_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/reg_ctx_engine.sv
// Streams an inclusive, wrapping register range out of (save) or into (restore) the register file.
// Define CTX_CHECKSUM_EN to build the ctx_chk transfer checksum; otherwise chk is tied to 0.
module reg_ctx_engine
    import ctx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    input  logic [REG_W-1:0]  first,
    input  logic [REG_W-1:0]  last,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rf_own,
    output logic              rf_wr,
    output logic [REG_W-1:0]  rf_rno,
    output logic [DATA_W-1:0] rf_din,
    input  logic [DATA_W-1:0] rf_dout,
    output logic              so_valid,
    input  logic              so_ready,
    output logic [DATA_W-1:0] so_data,
    output logic              so_last,
    input  logic              si_valid,
    output logic              si_ready,
    input  logic [DATA_W-1:0] si_data,
    output logic [DATA_W-1:0] chk
);

    ctx_state_e        state_q, state_d;
    logic [REG_W-1:0]  idx_q, idx_d;
    logic [REG_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] so_data_q, so_data_d;
    logic              so_valid_q, so_valid_d;

    logic              active_c;
    logic              rf_wr_c;
    logic [REG_W-1:0]  rf_rno_c;
    logic [DATA_W-1:0] rf_din_c;
    logic              si_ready_c;
    logic              so_last_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rem_q      <= '0;
            so_data_q  <= '0;
            so_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            so_data_q  <= so_data_d;
            so_valid_q <= so_valid_d;
        end
    end

    // Next-state and register-file/stream control.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        so_data_d  = so_data_q;
        so_valid_d = so_valid_q;
        active_c   = 1'b0;
        rf_wr_c    = 1'b0;
        rf_rno_c   = idx_q;
        rf_din_c   = '0;
        si_ready_c = 1'b0;
        so_last_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    idx_d = first;
                    rem_d = REG_W'(last - first);
                    case (op)
                        OP_SAVE:    state_d = ST_SAVE_LD;
                        OP_RESTORE: state_d = ST_RESTORE;
                    endcase
                end
            end

            ST_SAVE_LD: begin
                active_c = 1'b1;
                if (abort) begin
                    so_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    so_data_d  = rf_dout;
                    so_valid_d = 1'b1;
                    state_d    = ST_SAVE_TX;
                end
            end

            ST_SAVE_TX: begin
                active_c  = 1'b1;
                so_last_c = (rem_q == '0);
                if (abort) begin
                    so_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (so_ready) begin
                    if (rem_q != '0) begin
                        // Prefetch the following register so a word leaves every cycle.
                        idx_d     = next_idx(idx_q);
                        rem_d     = REG_W'(rem_q - 1'b1);
                        rf_rno_c  = next_idx(idx_q);
                        so_data_d = rf_dout;
                    end else begin
                        so_valid_d = 1'b0;
                        state_d    = ST_DONE;
                    end
                end
            end

            ST_RESTORE: begin
                active_c   = 1'b1;
                si_ready_c = 1'b1;
                rf_din_c   = si_data;
                rf_wr_c    = si_valid;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (si_valid) begin
                    if (rem_q != '0) begin
                        idx_d = next_idx(idx_q);
                        rem_d = REG_W'(rem_q - 1'b1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                so_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    assign busy     = active_c;
    assign rf_own   = active_c;
    assign done     = (state_q == ST_DONE);
    assign rf_wr    = rf_wr_c;
    assign rf_rno   = rf_rno_c;
    assign rf_din   = rf_din_c;
    assign si_ready = si_ready_c;
    assign so_valid = so_valid_q;
    assign so_data  = so_data_q;
    assign so_last  = so_last_c;

`ifdef CTX_CHECKSUM_EN
    logic              sum_clr;
    logic              sum_add;
    logic [DATA_W-1:0] sum_word;

    // A save word counts at its stream handshake, a restore word at its register write.
    assign sum_clr  = (state_q == ST_IDLE) && start && !abort;
    assign sum_add  = ((state_q == ST_SAVE_TX) && so_ready) || rf_wr_c;
    assign sum_word = rf_wr_c ? si_data : so_data_q;

    ctx_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (sum_clr),
        .add_i  (sum_add),
        .word_i (sum_word),
        .sum_o  (chk)
    );
`else
    assign chk = '0;
`endif

endmodule

// File: tb/tb_reg_ctx_engine.sv
// Randomized self-checking bench for reg_ctx_engine against a register-file/stream reference model.
module tb_reg_ctx_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [3:0]  first;
    logic [3:0]  last;
    logic        abort;
    logic        busy;
    logic        done;
    logic        rf_own;
    logic        rf_wr;
    logic [3:0]  rf_rno;
    logic [31:0] rf_din;
    logic [31:0] rf_dout;
    logic        so_valid;
    logic        so_ready;
    logic [31:0] so_data;
    logic        so_last;
    logic        si_valid;
    logic        si_ready;
    logic [31:0] si_data;
    logic [31:0] chk;

    logic [31:0] rf_mem   [16];
    logic [31:0] model_rf [16];
    logic        preload;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    reg_ctx_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .first    (first),
        .last     (last),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .rf_own   (rf_own),
        .rf_wr    (rf_wr),
        .rf_rno   (rf_rno),
        .rf_din   (rf_din),
        .rf_dout  (rf_dout),
        .so_valid (so_valid),
        .so_ready (so_ready),
        .so_data  (so_data),
        .so_last  (so_last),
        .si_valid (si_valid),
        .si_ready (si_ready),
        .si_data  (si_data),
        .chk      (chk)
    );

    // Register file seen by the engine: combinational read, clocked write.
    assign rf_dout = rf_mem[rf_rno];
    always @(posedge clk) begin
        if (preload) rf_mem <= model_rf;
        else if (rf_wr) rf_mem[rf_rno] <= rf_din;
    end

    always @(negedge clk) begin
        if (rf_wr) wr_cnt++;
        if (done)  done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_chk(input logic [31:0] s);
`ifdef CTX_CHECKSUM_EN
        return s;
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) check(tag, rf_mem[i], model_rf[i]);
    endtask

    // mode: 0 ready always, 1 ready on odd cycles, 2 random ready.
    task automatic run_save(input logic [3:0] f, input logic [3:0] l, input int mode,
                            input int abort_at, input bit poke_start);
        logic [31:0] exp_q[$];
        logic [31:0] sum;
        logic [31:0] held;
        logic [3:0]  span;
        logic [3:0]  r;
        int n, got, cyc, done_cyc, d0;
        bit held_v, aborted;

        span = l - f;
        n    = int'(span) + 1;
        sum  = 32'd0;
        for (int k = 0; k < n; k++) begin
            r = f + 4'(k);
            exp_q.push_back(model_rf[r]);
            sum = sum + model_rf[r];
        end

        op = 1'b0; first = f; last = l; start = 1'b1; so_ready = 1'b0;
        tick();
        start = 1'b0;
        got = 0; cyc = 0; done_cyc = -1; held_v = 1'b0; aborted = 1'b0; held = 32'd0;

        while (cyc < 200 && done_cyc < 0 && !aborted) begin
            case (mode)
                0:       so_ready = 1'b1;
                1:       so_ready = (cyc % 2 == 1);
                default: so_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke_start && cyc == 2) begin
                start = 1'b1; op = 1'b1; first = ~f;
            end else begin
                start = 1'b0;
            end
            if (abort_at >= 0 && got == abort_at) begin
                abort = 1'b1; so_ready = 1'b0;
            end
            @(negedge clk);
            if (abort) begin
                @(posedge clk); #1;
                abort = 1'b0;
                @(negedge clk);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_so_valid", 32'(so_valid), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                aborted = 1'b1;
                @(posedge clk); #1;
            end else begin
                if (held_v && so_valid) check("so_hold", so_data, held);
                held_v = so_valid && !so_ready;
                held   = so_data;
                if (so_valid && so_ready) begin
                    if (got < n) begin
                        check("so_data", so_data, exp_q[got]);
                        check("so_last", 32'(so_last), 32'(got == n - 1));
                    end else begin
                        check("extra_word", 32'(got), 32'(n - 1));
                    end
                    got++;
                end
                if (done) done_cyc = cyc;
                cyc++;
                @(posedge clk); #1;
            end
        end
        start = 1'b0; so_ready = 1'b0;

        if (aborted) begin
            d0 = done_cnt;
            repeat (3) tick();
            check("abort_no_done", 32'(done_cnt - d0), 32'd0);
            check("abort_words", 32'(got), 32'(abort_at));
        end else begin
            check("save_words", 32'(got), 32'(n));
            check("save_done_seen", 32'(done_cyc >= 0), 32'd1);
            if (mode == 0 && !poke_start) check("save_latency", 32'(done_cyc), 32'(n + 1));
            @(negedge clk);
            check("save_done_pulse", 32'(done), 32'd0);
            check("save_idle_busy", 32'(busy), 32'd0);
            check("save_chk", chk, exp_chk(sum));
            @(posedge clk); #1;
        end
    endtask

    // mode: 0 valid always, 1 gap every 3rd cycle, 2 random valid.
    task automatic run_restore(input logic [3:0] f, input logic [3:0] l, input int mode,
                               input bit seq, input int rst_at);
        logic [31:0] data[$];
        logic [31:0] sum;
        logic [3:0]  span;
        logic [3:0]  r;
        int n, sent, cyc, done_cyc, w0, d0;
        bit rst_done;

        span = l - f;
        n    = int'(span) + 1;
        for (int k = 0; k < n; k++) data.push_back(seq ? 32'h100 + 32'(k) : $urandom);

        op = 1'b1; first = f; last = l; start = 1'b1;
        tick();
        start = 1'b0;
        w0 = wr_cnt; d0 = done_cnt;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_own", 32'(rf_own), 32'd1);
        check("rst_si_ready", 32'(si_ready), 32'd1);
        @(posedge clk); #1;

        sum = 32'd0; sent = 0; cyc = 0; done_cyc = -1; rst_done = 1'b0;
        while (cyc < 300 && done_cyc < 0 && !rst_done) begin
            if (rst_at >= 0 && sent == rst_at) begin
                si_valid = 1'b1; si_data = data[sent];
                rst_n = 1'b0;
                #1;
                check("mid_reset_busy", 32'(busy), 32'd0);
                check("mid_reset_own", 32'(rf_own), 32'd0);
                check("mid_reset_wr", 32'(rf_wr), 32'd0);
                check("mid_reset_si_ready", 32'(si_ready), 32'd0);
                check("mid_reset_done", 32'(done), 32'd0);
                check("mid_reset_so_valid", 32'(so_valid), 32'd0);
                check("mid_reset_so_data", so_data, 32'd0);
                check("mid_reset_chk", chk, 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                si_valid = 1'b0;
                @(posedge clk); #1;
                rst_done = 1'b1;
            end else begin
                case (mode)
                    0:       si_valid = (sent < n);
                    1:       si_valid = (sent < n) && (cyc % 3 != 2);
                    default: si_valid = (sent < n) && 1'($urandom_range(0, 1));
                endcase
                si_data = si_valid ? data[sent] : $urandom;
                @(negedge clk);
                if (si_valid && si_ready) begin
                    r = f + 4'(sent);
                    check("rf_wr", 32'(rf_wr), 32'd1);
                    check("rf_rno", 32'(rf_rno), 32'(r));
                    check("rf_din", rf_din, data[sent]);
                    model_rf[r] = data[sent];
                    sum = sum + data[sent];
                    sent++;
                end else if (!si_valid) begin
                    check("rf_wr_gap", 32'(rf_wr), 32'd0);
                end
                if (done) done_cyc = cyc;
                cyc++;
                @(posedge clk); #1;
            end
        end
        si_valid = 1'b0;

        if (rst_done) begin
            check("reset_writes", 32'(wr_cnt - w0), 32'(rst_at));
            check("reset_no_done", 32'(done_cnt - d0), 32'd0);
            check("reset_idle_busy", 32'(busy), 32'd0);
        end else begin
            check("restore_writes", 32'(wr_cnt - w0), 32'(n));
            check("restore_done_seen", 32'(done_cyc >= 0), 32'd1);
            @(negedge clk);
            check("restore_done_once", 32'(done_cnt - d0), 32'd1);
            check("restore_idle_busy", 32'(busy), 32'd0);
            check("restore_chk", chk, exp_chk(sum));
            @(posedge clk); #1;
        end
        check_regs("regfile");
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; first = 4'd0; last = 4'd0; abort = 1'b0;
        so_ready = 1'b0; si_valid = 1'b0; si_data = 32'd0; preload = 1'b1;
        for (int i = 0; i < 16; i++) model_rf[i] = $urandom;
        model_rf[3] = 32'h11; model_rf[4] = 32'h22; model_rf[5] = 32'h33;
        repeat (3) @(posedge clk);
        preload = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_own", 32'(rf_own), 32'd0);
        check("reset_rf_wr", 32'(rf_wr), 32'd0);
        check("reset_si_ready", 32'(si_ready), 32'd0);
        check("reset_so_valid", 32'(so_valid), 32'd0);
        check("reset_so_data", so_data, 32'd0);
        check("reset_chk", chk, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_save(4'd3, 4'd5, 0, -1, 1'b0);
        run_save(4'd15, 4'd0, 1, -1, 1'b0);
        run_restore(4'd0, 4'd15, 1, 1'b1, -1);
        run_save(4'd2, 4'd9, 0, 2, 1'b0);
        run_save(4'd2, 4'd9, 0, -1, 1'b0);
        run_save(4'd6, 4'd10, 2, -1, 1'b1);

        // start together with abort in IDLE must not launch anything
        op = 1'b0; first = 4'd3; last = 4'd5; start = 1'b1; abort = 1'b1;
        d0 = done_cnt;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_busy", 32'(busy), 32'd0);
        check("start_abort_so_valid", 32'(so_valid), 32'd0);
        @(posedge clk); #1;
        repeat (3) tick();
        check("start_abort_no_done", 32'(done_cnt - d0), 32'd0);

        run_restore(4'd0, 4'd15, 0, 1'b0, 4);
        run_save(4'd14, 4'd1, 0, -1, 1'b0);

        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1)
                run_restore(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2, 1'b0, -1);
            else
                run_save(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
